// File: rtl/regfile_write_arbiter_if.sv
// Writeback bus between the ALU/load sources and the register file write arbiter.
// The master modport is the source/register-file side; the slave modport is the arbiter.
interface regfile_write_arbiter_if #(
    parameter int DATA_W  = 8,
    parameter int REG_CNT = 4
);
    localparam int AW = (REG_CNT > 1) ? $clog2(REG_CNT) : 1;

    logic              alu_valid;
    logic [AW-1:0]     alu_reg;
    logic [DATA_W-1:0] alu_data;
    logic              alu_ready;
    logic              ld_valid;
    logic [AW-1:0]     ld_reg;
    logic [DATA_W-1:0] ld_data;
    logic              ld_ready;
    logic              write_en;
    logic [AW-1:0]     write_reg;
    logic [DATA_W-1:0] write_value;
    logic [REG_CNT-1:0] pending;
    logic [7:0]        conflict_cnt;

    modport master (
        output alu_valid, alu_reg, alu_data, ld_valid, ld_reg, ld_data,
        input  alu_ready, ld_ready, write_en, write_reg, write_value, pending, conflict_cnt
    );

    modport slave (
        input  alu_valid, alu_reg, alu_data, ld_valid, ld_reg, ld_data,
        output alu_ready, ld_ready, write_en, write_reg, write_value, pending, conflict_cnt
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Arbitrates the single register-file write port between ALU and load writeback buffers.
// Optional macro REGFILE_ARB_COALESCE_EN merges same-register entries into one write.
module regfile_write_arbiter #(
    parameter int DATA_W  = 8,
    parameter int REG_CNT = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    regfile_write_arbiter_if.slave bus
);
    localparam int AW = (REG_CNT > 1) ? $clog2(REG_CNT) : 1;

    logic              alu_full_r;
    logic [AW-1:0]     alu_reg_r;
    logic [DATA_W-1:0] alu_data_r;
    logic              ld_full_r;
    logic [AW-1:0]     ld_reg_r;
    logic [DATA_W-1:0] ld_data_r;
    logic              alu_older_r;
    logic              age_eq_r;
    logic              rr_r;
    logic              write_en_r;
    logic [AW-1:0]     write_reg_r;
    logic [DATA_W-1:0] write_value_r;
    logic [7:0]        conflict_cnt_r;

    logic              alu_grant_s;
    logic              ld_grant_s;
    logic              tie_s;
    logic              sel_ld_s;
    logic              alu_load_s;
    logic              ld_load_s;
    logic [REG_CNT-1:0] pending_s;

    // Grant selection: oldest entry first, round-robin on equal age.
    always_comb begin
        alu_grant_s = 1'b0;
        ld_grant_s  = 1'b0;
        tie_s       = 1'b0;
        sel_ld_s    = 1'b0;
        if (alu_full_r && ld_full_r) begin
`ifdef REGFILE_ARB_COALESCE_EN
            // Same target: both drain, only the younger value (load on a tie) is written.
            if (alu_reg_r == ld_reg_r) begin
                alu_grant_s = 1'b1;
                ld_grant_s  = 1'b1;
                sel_ld_s    = age_eq_r || alu_older_r;
            end else
`endif
            if (age_eq_r) begin
                tie_s       = 1'b1;
                sel_ld_s    = rr_r;
                alu_grant_s = !rr_r;
                ld_grant_s  = rr_r;
            end else if (alu_older_r) begin
                alu_grant_s = 1'b1;
            end else begin
                ld_grant_s  = 1'b1;
                sel_ld_s    = 1'b1;
            end
        end else if (alu_full_r) begin
            alu_grant_s = 1'b1;
        end else if (ld_full_r) begin
            ld_grant_s  = 1'b1;
            sel_ld_s    = 1'b1;
        end else begin
            alu_grant_s = 1'b0;
        end
    end

    assign bus.alu_ready = reset_n && (!alu_full_r || alu_grant_s);
    assign bus.ld_ready  = reset_n && (!ld_full_r  || ld_grant_s);
    assign alu_load_s    = bus.alu_valid && bus.alu_ready;
    assign ld_load_s     = bus.ld_valid  && bus.ld_ready;

    // Buffers, age tracking, write port and conflict counter.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            alu_full_r     <= 1'b0;
            alu_reg_r      <= {AW{1'b0}};
            alu_data_r     <= {DATA_W{1'b0}};
            ld_full_r      <= 1'b0;
            ld_reg_r       <= {AW{1'b0}};
            ld_data_r      <= {DATA_W{1'b0}};
            alu_older_r    <= 1'b0;
            age_eq_r       <= 1'b0;
            rr_r           <= 1'b0;
            write_en_r     <= 1'b0;
            write_reg_r    <= {AW{1'b0}};
            write_value_r  <= {DATA_W{1'b0}};
            conflict_cnt_r <= 8'd0;
        end else begin
            if (alu_load_s) begin
                alu_full_r <= 1'b1;
                alu_reg_r  <= bus.alu_reg;
                alu_data_r <= bus.alu_data;
            end else if (alu_grant_s) begin
                alu_full_r <= 1'b0;
            end else begin
                alu_full_r <= alu_full_r;
            end

            if (ld_load_s) begin
                ld_full_r <= 1'b1;
                ld_reg_r  <= bus.ld_reg;
                ld_data_r <= bus.ld_data;
            end else if (ld_grant_s) begin
                ld_full_r <= 1'b0;
            end else begin
                ld_full_r <= ld_full_r;
            end

            // The entry that did not load this edge (if any) is the older one.
            if (alu_load_s && ld_load_s) begin
                age_eq_r    <= 1'b1;
                alu_older_r <= 1'b0;
            end else if (alu_load_s) begin
                age_eq_r    <= 1'b0;
                alu_older_r <= 1'b0;
            end else if (ld_load_s) begin
                age_eq_r    <= 1'b0;
                alu_older_r <= 1'b1;
            end else begin
                age_eq_r    <= age_eq_r;
                alu_older_r <= alu_older_r;
            end

            if (tie_s) begin
                rr_r <= ~rr_r;
            end else begin
                rr_r <= rr_r;
            end

            write_en_r <= alu_grant_s || ld_grant_s;
            if (alu_grant_s || ld_grant_s) begin
                write_reg_r   <= sel_ld_s ? ld_reg_r  : alu_reg_r;
                write_value_r <= sel_ld_s ? ld_data_r : alu_data_r;
            end else begin
                write_reg_r   <= write_reg_r;
                write_value_r <= write_value_r;
            end

            if (alu_full_r && ld_full_r && (conflict_cnt_r != 8'd255)) begin
                conflict_cnt_r <= conflict_cnt_r + 8'd1;
            end else begin
                conflict_cnt_r <= conflict_cnt_r;
            end
        end
    end

    // Hazard scoreboard decoded from registered state only.
    always_comb begin
        pending_s = {REG_CNT{1'b0}};
        for (int r = 0; r < REG_CNT; r++) begin
            pending_s[r] = (alu_full_r && (alu_reg_r == AW'(r))) ||
                           (ld_full_r  && (ld_reg_r  == AW'(r))) ||
                           (write_en_r && (write_reg_r == AW'(r)));
        end
    end

    assign bus.write_en     = write_en_r;
    assign bus.write_reg    = write_reg_r;
    assign bus.write_value  = write_value_r;
    assign bus.pending      = pending_s;
    assign bus.conflict_cnt = conflict_cnt_r;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized scoreboard bench for regfile_write_arbiter: an age-stamped reference model
// predicts writes into a queue that an independent monitor checks against the write port.
module tb_regfile_write_arbiter;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    regfile_write_arbiter_if #(.DATA_W(8), .REG_CNT(4)) bus ();
    regfile_write_arbiter #(.DATA_W(8), .REG_CNT(4)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    typedef struct {
        logic [1:0]  wreg;
        logic [7:0]  wval;
        int unsigned edge_no;
    } exp_t;

    exp_t        exp_q[$];
    int          tests = 0;
    int          fails = 0;
    int unsigned edge_cnt = 0;

    // Reference model: each buffer entry carries the edge number at which it was accepted.
    logic        m_full[2];
    logic [1:0]  m_reg[2];
    logic [7:0]  m_data[2];
    int unsigned m_stamp[2];
    logic        m_rr;
    int          m_cnt;
    logic        m_last_wen;
    logic [1:0]  m_last_reg;

    always @(posedge clk) edge_cnt++;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at edge %0d", name, act, act, exp, exp, edge_cnt);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_full[i] = 1'b0; m_reg[i] = 2'd0; m_data[i] = 8'd0; m_stamp[i] = 0;
        end
        m_rr = 1'b0; m_cnt = 0; m_last_wen = 1'b0; m_last_reg = 2'd0;
    endtask

    // Monitor: every write the DUT issues must match the next predicted write and its edge.
    always @(negedge clk) begin
        exp_t e;
        if (bus.write_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL write_unexpected: got write reg=%0d value=0x%0h, expected no write (edge %0d)",
                         bus.write_reg, bus.write_value, edge_cnt);
            end else begin
                e = exp_q.pop_front();
                check("write_reg",   32'(bus.write_reg),   32'(e.wreg));
                check("write_value", 32'(bus.write_value), 32'(e.wval));
                check("write_edge",  edge_cnt,             e.edge_no);
            end
        end else if (exp_q.size() != 0 && exp_q[0].edge_no <= edge_cnt) begin
            e = exp_q.pop_front();
            tests++; fails++;
            $display("FAIL write_missing: got no write, expected reg=%0d value=0x%0h at edge %0d",
                     e.wreg, e.wval, e.edge_no);
        end
    end

    // One clock cycle: check state outputs, apply inputs, check readies, advance the model.
    task automatic step(input logic av, input logic [1:0] ar, input logic [7:0] ad,
                        input logic lv, input logic [1:0] lr, input logic [7:0] ld, input logic rn);
        logic [3:0] pexp;
        logic ga, gl, tie, coal, ra, rl;
        int   winner;
        exp_t e;
        @(negedge clk);
        pexp = 4'd0;
        for (int i = 0; i < 2; i++) if (m_full[i]) pexp[m_reg[i]] = 1'b1;
        if (m_last_wen) pexp[m_last_reg] = 1'b1;
        check("pending", 32'(bus.pending), 32'(pexp));
        check("conflict_cnt", 32'(bus.conflict_cnt), 32'(m_cnt));

        bus.alu_valid = av; bus.alu_reg = ar; bus.alu_data = ad;
        bus.ld_valid  = lv; bus.ld_reg  = lr; bus.ld_data  = ld;
        reset_n = rn;
        #1;

        ga = 1'b0; gl = 1'b0; tie = 1'b0; coal = 1'b0; winner = 0;
        if (m_full[0] && m_full[1]) begin
`ifdef REGFILE_ARB_COALESCE_EN
            coal = (m_reg[0] == m_reg[1]);
`endif
            if (coal) begin
                ga = 1'b1; gl = 1'b1;
                winner = (m_stamp[1] >= m_stamp[0]) ? 1 : 0;
            end else begin
                if (m_stamp[0] == m_stamp[1]) begin
                    tie = 1'b1; winner = m_rr ? 1 : 0;
                end else begin
                    winner = (m_stamp[0] < m_stamp[1]) ? 0 : 1;
                end
                ga = (winner == 0); gl = (winner == 1);
            end
        end else if (m_full[0]) begin
            ga = 1'b1; winner = 0;
        end else if (m_full[1]) begin
            gl = 1'b1; winner = 1;
        end

        ra = rn && (!m_full[0] || ga);
        rl = rn && (!m_full[1] || gl);
        check("alu_ready", 32'(bus.alu_ready), 32'(ra));
        check("ld_ready",  32'(bus.ld_ready),  32'(rl));

        if (!rn) begin
            model_reset();
        end else begin
            if (m_full[0] && m_full[1] && m_cnt < 255) m_cnt++;
            m_last_wen = ga || gl;
            if (ga || gl) begin
                e.wreg = m_reg[winner]; e.wval = m_data[winner]; e.edge_no = edge_cnt + 1;
                exp_q.push_back(e);
                m_last_reg = m_reg[winner];
            end
            if (tie) m_rr = ~m_rr;
            if (ga) m_full[0] = 1'b0;
            if (gl) m_full[1] = 1'b0;
            if (av && ra) begin m_full[0] = 1'b1; m_reg[0] = ar; m_data[0] = ad; m_stamp[0] = edge_cnt + 1; end
            if (lv && rl) begin m_full[1] = 1'b1; m_reg[1] = lr; m_data[1] = ld; m_stamp[1] = edge_cnt + 1; end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 2'd0, 8'd0, 1'b0, 2'd0, 8'd0, 1'b1);
    endtask

    task automatic stream(input int n);
        for (int i = 0; i < n; i++)
            step(1'b1, 2'($urandom_range(0, 3)), 8'($urandom), 1'b1, 2'($urandom_range(0, 3)), 8'($urandom), 1'b1);
    endtask

    initial begin
        model_reset();
        bus.alu_valid = 1'b0; bus.alu_reg = 2'd0; bus.alu_data = 8'd0;
        bus.ld_valid  = 1'b0; bus.ld_reg  = 2'd0; bus.ld_data  = 8'd0;

        // Reset held with both sources requesting, then release.
        step(1'b1, 2'd0, 8'hFF, 1'b1, 2'd1, 8'hEE, 1'b0);
        step(1'b1, 2'd0, 8'hFF, 1'b1, 2'd1, 8'hEE, 1'b0);
        check("reset_write_en", 32'(bus.write_en), 32'd0);
        idle(1);

        // Single ALU write to register 2.
        step(1'b1, 2'd2, 8'hA5, 1'b0, 2'd0, 8'd0, 1'b1);
        idle(3);

        // Equal-age tie: ALU first, then load.
        step(1'b1, 2'd1, 8'h11, 1'b1, 2'd3, 8'h33, 1'b1);
        idle(3);
        check("tie_conflict_cnt", 32'(bus.conflict_cnt), 32'd1);

        // Age order on register 0: load 0x22 held while ALU 0x44 arrives later.
        step(1'b1, 2'd1, 8'h01, 1'b1, 2'd2, 8'h02, 1'b1);
        step(1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 8'h22, 1'b1);
        step(1'b1, 2'd0, 8'h44, 1'b0, 2'd0, 8'h00, 1'b1);
        idle(4);

        // Both sources streaming.
        stream(10);
        idle(4);

        // Counter saturation.
        stream(310);
        check("conflict_saturate", 32'(bus.conflict_cnt), 32'd255);

        // Reset with both buffers full discards them.
        step(1'b1, 2'd3, 8'h5A, 1'b1, 2'd3, 8'hA5, 1'b0);
        step(1'b1, 2'd3, 8'h5A, 1'b1, 2'd3, 8'hA5, 1'b0);
        idle(4);

        // Random traffic with occasional reset.
        for (int i = 0; i < 600; i++)
            step(1'($urandom_range(0, 2) != 0), 2'($urandom_range(0, 3)), 8'($urandom),
                 1'($urandom_range(0, 2) != 0), 2'($urandom_range(0, 3)), 8'($urandom),
                 1'($urandom_range(0, 99) != 0));
        idle(6);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the single write port of the 4 x 8-bit register file between two writeback sources: the ALU result path and the load unit. Each source gets a one-entry holding buffer with a valid/ready handshake. The arbiter picks one buffered write per cycle, oldest first and round-robin on ties, and drives registered `write_en`/`write_reg`/`write_value` into the register file. It also exports a per-register pending scoreboard so decode can stall on read-after-write hazards.

## Interface
Parameters:
- `DATA_W`, default 8: write data width.
- `REG_CNT`, default 4: number of registers. Address width is `AW = $clog2(REG_CNT)`, which is 2 by default.

Ports:
- `clk`  in  1  the single clock. All state updates on its rising edge.
- `reset_n`  in  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `alu_valid`  in  1  ALU write request.
- `alu_reg`  in  AW  ALU destination register.
- `alu_data`  in  DATA_W  ALU write data.
- `alu_ready`  out  1  ALU buffer can accept this cycle.
- `ld_valid`  in  1  load-unit write request.
- `ld_reg`  in  AW  load destination register.
- `ld_data`  in  DATA_W  load write data.
- `ld_ready`  out  1  load buffer can accept this cycle.
- `write_en`  out  1  registered; goes to the register file write enable.
- `write_reg`  out  AW  registered write address.
- `write_value`  out  DATA_W  registered write data.
- `pending`  out  REG_CNT  bit r = 1 while a write to register r is buffered or on the write port.
- `conflict_cnt`  out  8  saturating count of cycles in which both buffers were occupied.

## Operation
Buffers:
- Each source has a buffer with fields {full, reg, data}.
- A handshake (`valid && ready`) loads the buffer at the clock edge.
- `x_ready = !x_full || x_grant`, where `x_grant` is combinational for the current cycle.
- A granted buffer may be reloaded on the same edge it drains.

Age tracking:
- An `alu_older` flag is set when the ALU buffer holds data and the load buffer loads later.
- It is cleared in the symmetric case.
- If both buffers load on the same edge, the entries are equal-age.

Arbitration, evaluated each cycle:
- No buffer full: no grant.
- One buffer full: that buffer is granted.
- Both full with different ages: the older entry is granted.
- Both full and equal-age: the round-robin pointer `rr` decides (0 = ALU, 1 = load).
- After any equal-age tie grant, `rr` flips.

Write port:
- The granted entry loads `write_reg`/`write_value` and sets `write_en` = 1 at the same edge.
- With no grant, `write_en` = 0 and `write_reg`/`write_value` hold their values.

Scoreboard:
- `pending[r]` = (alu_full && alu_reg_q == r) || (ld_full && ld_reg_q == r) || (write_en && write_reg == r).
- It is purely combinational from registered state.

Conflict counter:
- `conflict_cnt` increments when both buffers are full.
- It saturates at 255.

Reset (`reset_n` = 0 at an edge):
- Both buffers are emptied and the age flag is cleared.
- `rr` = 0; `write_en` = 0; `write_reg` = 0; `write_value` = 0; `conflict_cnt` = 0.
- `alu_ready` and `ld_ready` are forced to 0 while `reset_n` is low, and go to 1 in the first cycle after release.
- Reset asserted mid-operation discards buffered writes without issuing them.

## Timing
- Handshake in cycle N → buffer full in N+1 → `write_en` high in N+2 → register file commits at the end of N+2.
- With a single active source the throughput is one write per cycle and `ready` stays high.
- With both sources streaming, each source gets every other cycle and its `ready` toggles.
- `pending[r]` rises in the cycle after the handshake and falls in the cycle after `write_en` for r was high, provided no new write to r is pending.

## Configuration
Macro: `REGFILE_ARB_COALESCE_EN`.
- Defined: when both buffers are full and target the same register, only the younger entry is written. The older entry is discarded, and both buffers clear on that edge. If the two entries are equal-age, load data wins. `rr` is not updated on a coalesce. A coalesce cycle still counts in `conflict_cnt`.
- Undefined: same-register entries are written sequentially in age order (ties by `rr`), so the younger value ends up in the register last.

## Test plan
- Reset: drive `reset_n` = 0 for 2 cycles with both valids high → `write_en` = 0, `pending` = 0, both readys 0, `conflict_cnt` = 0. After release, readys = 1.
- Single ALU write: `alu_reg` = 2, `alu_data` = 8'hA5 accepted in cycle N → `pending` = 4'b0100 in N+1. In N+2, `write_en` = 1, `write_reg` = 2, `write_value` = 8'hA5. `pending` = 0 in N+3.
- Equal-age tie: ALU (reg 1, 8'h11) and load (reg 3, 8'h33) accepted on the same edge after reset → ALU written first (`rr` = 0), load written the next cycle, `rr` = 1 afterward, `conflict_cnt` = 1.
- Age order: load (reg 0, 8'h22) accepted one cycle before ALU (reg 0, 8'h44) while the load is held → load written first, then ALU. Final register 0 value is 8'h44. With the macro defined, a single write of 8'h44 occurs.
- Streaming: both valids held high for 10 cycles → alternating grants, each `ready` toggling, `conflict_cnt` increases by 1 per both-full cycle, no write lost or duplicated.
- Saturation and mid-op reset: more than 300 conflict cycles → `conflict_cnt` stays at 255. Assert reset with both buffers full → no `write_en` follows.
